// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants: next-PC select encodings, default NOP/reset vector,
// and the sign-extension helper used for decoder offsets.
package fetch_pkg;

    typedef enum logic [2:0] {
        PC_NEXT_SEL_STALL       = 3'd0,
        PC_NEXT_SEL_NEXT        = 3'd1,
        PC_NEXT_SEL_PC_IMM      = 3'd2,
        PC_NEXT_SEL_RS1_IMM     = 3'd3,
        PC_NEXT_SEL_COND_PC_IMM = 3'd4
    } pc_next_sel_e;

    localparam logic [31:0] NOP_INSN_DEFAULT  = 32'h0000_0013;
    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

    // Sign-extend the low `width` bits of raw; bits above the field are discarded.
    function automatic logic [31:0] sext(input logic [31:0] raw, input int unsigned width);
        logic [31:0] hi_mask;
        hi_mask = 32'hFFFF_FFFF << width;
        return raw[width-1] ? (raw | hi_mask) : (raw & ~hi_mask);
    endfunction

endpackage

// File: rtl/fetch_npc.sv
// Combinational next-PC target selection and misaligned-target detection.
module fetch_npc
    import fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [2:0]  sel_i,
    input  logic [31:0] off_i,
    input  logic [2:0]  isize_i,
    input  logic [31:0] rs1_i,
    input  logic        cond_i,
    output logic [31:0] target_o,
    output logic        stall_o,
    output logic        misaligned_o
);

    logic [31:0] seq_pc;

    always_comb begin
        seq_pc   = pc_i + {29'd0, isize_i};
        target_o = pc_i;
        stall_o  = 1'b0;
        case (sel_i)
            PC_NEXT_SEL_NEXT:        target_o = seq_pc;
            PC_NEXT_SEL_PC_IMM:      target_o = pc_i + sext(off_i, 21);
            PC_NEXT_SEL_RS1_IMM:     target_o = (rs1_i + sext(off_i, 12)) & ~32'd1;
            PC_NEXT_SEL_COND_PC_IMM: target_o = cond_i ? (pc_i + sext(off_i, 13)) : seq_pc;
            default:                 stall_o  = 1'b1;
        endcase
        misaligned_o = !stall_o && (target_o[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch.sv
// pako32 instruction-fetch stage: PC register, sticky misalign trap, imem drive.
// Optional cycle/instret counters are built only when PAKO_FETCH_CNT_EN is defined.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
    parameter logic [31:0] NOP_INSN  = NOP_INSN_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [2:0]  pc_next_sel_i,
    input  logic [31:0] pc_next_off_i,
    input  logic [2:0]  pc_isize_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] alu_res_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_data_o,
    output logic        trap_o
`ifdef PAKO_FETCH_CNT_EN
    ,
    output logic [63:0] cycle_o,
    output logic [63:0] instret_o
`endif
);

    logic [31:0] pc_q, pc_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        trap_q, trap_d;
    logic [31:0] target;
    logic        stall;
    logic        misaligned;
    logic        unused_alu_bits;

    assign unused_alu_bits = ^alu_res_i[31:1];

    fetch_npc u_npc (
        .pc_i         (pc_q),
        .sel_i        (pc_next_sel_i),
        .off_i        (pc_next_off_i),
        .isize_i      (pc_isize_i),
        .rs1_i        (rs1_data_i),
        .cond_i       (alu_res_i[0]),
        .target_o     (target),
        .stall_o      (stall),
        .misaligned_o (misaligned)
    );

    always_comb begin
        pc_d          = pc_q;
        trap_d        = trap_q;
        fetch_valid_d = 1'b1;
        if (!trap_q && !stall) begin
            if (misaligned) begin
                trap_d = 1'b1;
            end else begin
                pc_d = target;
            end
        end
    end

    // The memory samples the address at the same edge that loads pc, so it sees pc_d;
    // during reset pc_q already holds RESET_VEC.
    assign imem_addr_o = rstn_i ? pc_d : pc_q;
    assign pc_o        = pc_q;
    assign trap_o      = trap_q;
    assign pc_data_o   = (fetch_valid_q && !trap_q) ? imem_rdata_i : NOP_INSN;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pc_q          <= RESET_VEC;
            fetch_valid_q <= 1'b0;
            trap_q        <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            trap_q        <= trap_d;
        end
    end

`ifdef PAKO_FETCH_CNT_EN
    logic [63:0] cycle_q, cycle_d;
    logic [63:0] instret_q, instret_d;

    always_comb begin
        cycle_d   = cycle_q + 64'd1;
        instret_d = instret_q;
        if (fetch_valid_q && !trap_q && !stall) begin
            instret_d = instret_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_o   = cycle_q;
    assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed table-driven bench for the fetch stage with a synchronous imem model.
module tb_fetch;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [2:0]  S_STL = 3'd0;
    localparam logic [2:0]  S_NXT = 3'd1;
    localparam logic [2:0]  S_PCI = 3'd2;
    localparam logic [2:0]  S_RSI = 3'd3;
    localparam logic [2:0]  S_CND = 3'd4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  sel;
    logic [31:0] off;
    logic [2:0]  isize;
    logic [31:0] rs1;
    logic [31:0] alu;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_data;
    logic        trap;
`ifdef PAKO_FETCH_CNT_EN
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fetch #(.RESET_VEC(32'h0000_0000), .NOP_INSN(NOP)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .pc_next_sel_i (sel),
        .pc_next_off_i (off),
        .pc_isize_i    (isize),
        .rs1_data_i    (rs1),
        .alu_res_i     (alu),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .pc_o          (pc),
        .pc_data_o     (pc_data),
        .trap_o        (trap)
`ifdef PAKO_FETCH_CNT_EN
        ,
        .cycle_o       (cycle_cnt),
        .instret_o     (instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'd0) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
    endfunction

    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] s, input logic [31:0] o, input logic [2:0] sz,
                         input logic [31:0] r, input logic a);
        sel   = s;
        off   = o;
        isize = sz;
        rs1   = r;
        alu   = {31'd0, a};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] off;
        logic [2:0]  isize;
        logic [31:0] rs1;
        logic        alu;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic        exp_trap;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic [2:0] s, input logic [31:0] o, input logic [2:0] sz,
                                input logic [31:0] r, input logic a, input logic [31:0] ea,
                                input logic [31:0] ep, input logic et);
        vec_t v;
        v.sel = s; v.off = o; v.isize = sz; v.rs1 = r; v.alu = a;
        v.exp_addr = ea; v.exp_pc = ep; v.exp_trap = et;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(S_NXT, 32'h0,         3'd4, 32'h0,         1'b0, 32'h4,         32'h4,         1'b0);
        vecs[1]  = mk(S_RSI, 32'h0,         3'd4, 32'h100,       1'b0, 32'h100,       32'h100,       1'b0);
        vecs[2]  = mk(S_PCI, 32'h1F_FFF8,   3'd4, 32'h0,         1'b0, 32'hF8,        32'hF8,        1'b0);
        vecs[3]  = mk(S_RSI, 32'h0,         3'd4, 32'h40,        1'b0, 32'h40,        32'h40,        1'b0);
        vecs[4]  = mk(S_CND, 32'h1FF0,      3'd4, 32'h0,         1'b1, 32'h30,        32'h30,        1'b0);
        vecs[5]  = mk(S_RSI, 32'h0,         3'd4, 32'h40,        1'b0, 32'h40,        32'h40,        1'b0);
        vecs[6]  = mk(S_CND, 32'h1FF0,      3'd4, 32'h0,         1'b0, 32'h44,        32'h44,        1'b0);
        vecs[7]  = mk(S_STL, 32'h40,        3'd4, 32'h0,         1'b1, 32'h44,        32'h44,        1'b0);
        vecs[8]  = mk(3'd5,  32'h40,        3'd4, 32'h0,         1'b1, 32'h44,        32'h44,        1'b0);
        vecs[9]  = mk(S_PCI, 32'hFFE0_0010, 3'd4, 32'h0,         1'b0, 32'h54,        32'h54,        1'b0);
        vecs[10] = mk(S_RSI, 32'hFFF,       3'd4, 32'h1001,      1'b0, 32'h1000,      32'h1000,      1'b0);
        vecs[11] = mk(S_RSI, 32'hFFE,       3'd4, 32'h1003,      1'b0, 32'h1000,      32'h1000,      1'b0);
        vecs[12] = mk(S_RSI, 32'h0,         3'd4, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        vecs[13] = mk(S_NXT, 32'h0,         3'd4, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0);
        vecs[14] = mk(S_CND, 32'h0800,      3'd4, 32'h0,         1'b1, 32'h800,       32'h800,       1'b0);
        vecs[15] = mk(S_PCI, 32'h10_0000,   3'd4, 32'h0,         1'b0, 32'hFFF0_0800, 32'hFFF0_0800, 1'b0);
        vecs[16] = mk(S_RSI, 32'h0,         3'd4, 32'h1002,      1'b0, 32'hFFF0_0800, 32'hFFF0_0800, 1'b1);
        vecs[17] = mk(S_NXT, 32'h0,         3'd4, 32'h0,         1'b0, 32'hFFF0_0800, 32'hFFF0_0800, 1'b1);
        vecs[18] = mk(S_PCI, 32'h8,         3'd4, 32'h0,         1'b0, 32'hFFF0_0800, 32'hFFF0_0800, 1'b1);

        rstn = 1'b0;
        drive(S_NXT, 32'h0, 3'd4, 32'h0, 1'b0);
        tick();
        tick();
        check("rst_pc", 0, {32'd0, pc}, 64'h0);
        check("rst_addr", 0, {32'd0, imem_addr}, 64'h0);
        check("rst_data", 0, {32'd0, pc_data}, {32'd0, NOP});
        check("rst_trap", 0, {63'd0, trap}, 64'h0);
`ifdef PAKO_FETCH_CNT_EN
        check("rst_cycle", 0, cycle_cnt, 64'h0);
        check("rst_instret", 0, instret_cnt, 64'h0);
`endif

        rstn = 1'b1;
        drive(S_STL, 32'h0, 3'd4, 32'h0, 1'b0);
        #1;
        check("c1_data", 0, {32'd0, pc_data}, {32'd0, NOP});
        check("c1_addr", 0, {32'd0, imem_addr}, 64'h0);
        tick();
        check("c2_data", 0, {32'd0, pc_data}, 64'h0050_0093);
        check("c2_pc", 0, {32'd0, pc}, 64'h0);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].sel, vecs[i].off, vecs[i].isize, vecs[i].rs1, vecs[i].alu);
            #1;
            check("addr", i, {32'd0, imem_addr}, {32'd0, vecs[i].exp_addr});
            tick();
            check("pc", i, {32'd0, pc}, {32'd0, vecs[i].exp_pc});
            check("trap", i, {63'd0, trap}, {63'd0, vecs[i].exp_trap});
            check("data", i, {32'd0, pc_data},
                  {32'd0, vecs[i].exp_trap ? NOP : mem_word(vecs[i].exp_pc)});
        end

        // Asynchronous reset between edges clears a set trap immediately.
        #2;
        rstn = 1'b0;
        #1;
        check("arst_pc", 0, {32'd0, pc}, 64'h0);
        check("arst_trap", 0, {63'd0, trap}, 64'h0);
        check("arst_data", 0, {32'd0, pc_data}, {32'd0, NOP});
        check("arst_addr", 0, {32'd0, imem_addr}, 64'h0);
        tick();
        rstn = 1'b1;
        drive(S_STL, 32'h0, 3'd4, 32'h0, 1'b0);
        tick();
        // PC-relative target with bit 1 set must trap and hold the PC.
        drive(S_PCI, 32'h2, 3'd4, 32'h0, 1'b0);
        #1;
        check("mis_addr", 0, {32'd0, imem_addr}, 64'h0);
        tick();
        check("mis_trap", 0, {63'd0, trap}, 64'h1);
        check("mis_pc", 0, {32'd0, pc}, 64'h0);
        check("mis_data", 0, {32'd0, pc_data}, {32'd0, NOP});

        // Branch fall-through with odd isize lands misaligned and traps.
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        drive(S_STL, 32'h0, 3'd4, 32'h0, 1'b0);
        tick();
        drive(S_CND, 32'h10, 3'd2, 32'h0, 1'b0);
        tick();
        check("cnd_trap", 0, {63'd0, trap}, 64'h1);
        check("cnd_pc", 0, {32'd0, pc}, 64'h0);

`ifdef PAKO_FETCH_CNT_EN
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        begin
            logic [2:0] seq[10];
            seq = '{S_STL, S_NXT, S_NXT, S_STL, S_NXT, S_NXT, S_STL, S_NXT, S_NXT, S_NXT};
            for (int k = 0; k < 10; k++) begin
                drive(seq[k], 32'h0, 3'd4, 32'h0, 1'b0);
                tick();
            end
        end
        check("cycle", 0, cycle_cnt, 64'd10);
        check("instret", 0, instret_cnt, 64'd7);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish, expected finish before 20000");
        $fatal(1);
    end

endmodule
